// File: rtl/cs_limb_resolver_if.sv
// cs_limb_resolver_if: column-in / limb-out handshake bundle (out_idx exists only with CS_LIMB_RESOLVER_IDX_EN)
interface cs_limb_resolver_if #(
   parameter int IN_W   = 23,
   parameter int LIMB_W = 17
);
   logic              in_valid, in_ready, in_last;
   logic [IN_W-1:0]   in_c, in_s;
   logic              out_valid, out_ready, out_last;
   logic [LIMB_W-1:0] out_limb;
`ifdef CS_LIMB_RESOLVER_IDX_EN
   logic [7:0]        out_idx;
   modport master (output in_valid, in_c, in_s, in_last, out_ready,
                   input  in_ready, out_valid, out_limb, out_last, out_idx);
   modport slave  (input  in_valid, in_c, in_s, in_last, out_ready,
                   output in_ready, out_valid, out_limb, out_last, out_idx);
`else
   modport master (output in_valid, in_c, in_s, in_last, out_ready,
                   input  in_ready, out_valid, out_limb, out_last);
   modport slave  (input  in_valid, in_c, in_s, in_last, out_ready,
                   output in_ready, out_valid, out_limb, out_last);
`endif
endinterface

// File: rtl/cs_limb_resolver.sv
// cs_limb_resolver: resolves per-column carry-save pairs into a limb stream plus a flush limb (optional out_idx via CS_LIMB_RESOLVER_IDX_EN)
module cs_limb_resolver #(
   parameter int IN_W    = 23,
   parameter int LIMB_W  = 17,
   parameter int CARRY_W = 8
) (
   input logic              clk_sq,
   input logic              reset_sq,
   cs_limb_resolver_if.slave bus
);
   typedef enum logic {ACCUM, FLUSH} state_t;
   state_t            state, state_nx;
   logic [CARRY_W-1:0] carry, carry_nx;
   logic [IN_W+1:0]   sum;
   logic [LIMB_W-1:0] limb_nx;
   logic              slot_free, take, load, last_nx;
`ifdef CS_LIMB_RESOLVER_IDX_EN
   logic [7:0]        idx_cnt;
`endif
   assign slot_free   = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = (state == ACCUM) && slot_free;
   assign take        = bus.in_valid && bus.in_ready;
   assign sum         = {2'b0, bus.in_c} + {2'b0, bus.in_s} + (IN_W+2)'(carry);
   // next state, next carry and the limb to load into the output slot
   always_comb begin
      state_nx = state;
      carry_nx = carry;
      load     = 1'b0;
      limb_nx  = sum[LIMB_W-1:0];
      last_nx  = 1'b0;
      if (take) begin
         load     = 1'b1;
         carry_nx = CARRY_W'(sum[IN_W+1:LIMB_W]);
         state_nx = bus.in_last ? FLUSH : ACCUM;
      end else if (state == FLUSH && slot_free) begin
         load     = 1'b1;
         limb_nx  = LIMB_W'(carry);
         last_nx  = 1'b1;
         carry_nx = '0;
         state_nx = ACCUM;
      end
   end
   // state, carry and output slot registers; a load overwrites a limb leaving this cycle
   always_ff @(posedge clk_sq) begin
      if (reset_sq) begin
         state         <= ACCUM;
         carry         <= '0;
         bus.out_valid <= 1'b0;
         bus.out_limb  <= '0;
         bus.out_last  <= 1'b0;
      end else begin
         state <= state_nx;
         carry <= carry_nx;
         if (load) begin
            bus.out_valid <= 1'b1;
            bus.out_limb  <= limb_nx;
            bus.out_last  <= last_nx;
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
      end
   end
`ifdef CS_LIMB_RESOLVER_IDX_EN
   // limb index within the product, restarting after the flush limb
   always_ff @(posedge clk_sq) begin
      if (reset_sq) begin
         idx_cnt     <= '0;
         bus.out_idx <= '0;
      end else if (load) begin
         bus.out_idx <= idx_cnt;
         idx_cnt     <= last_nx ? 8'd0 : idx_cnt + 8'd1;
      end
   end
`endif
endmodule

// File: tb/tb_cs_limb_resolver.sv
// tb_cs_limb_resolver: table-driven cycle vectors plus backpressure and mid-product reset sequences
module tb_cs_limb_resolver;
   logic clk_sq = 1'b0;
   logic reset_sq;
   int   n_chk = 0, n_pass = 0;

   cs_limb_resolver_if #(.IN_W(23), .LIMB_W(17)) bus ();
   cs_limb_resolver #(.IN_W(23), .LIMB_W(17), .CARRY_W(8)) dut (
      .clk_sq(clk_sq), .reset_sq(reset_sq), .bus(bus)
   );

   always #5 clk_sq = ~clk_sq;

   typedef struct {
      logic        v;
      logic [22:0] c, s;
      logic        l;
      logic        rdy;
      logic        ov;
      logic [16:0] limb;
      logic        lst;
      logic [7:0]  idx;
   } vec_t;
   vec_t tv [16];

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d]: got %h expected %h", nm, k, act, exp);
   endtask

   task automatic drive(input logic v, input logic [22:0] c, input logic [22:0] s, input logic l);
      bus.in_valid = v;
      bus.in_c     = c;
      bus.in_s     = s;
      bus.in_last  = l;
   endtask

   initial begin
      // single column 7FFFFF+7FFFFF: 0xFFFFFE -> limb 1FFFE, carry 7F
      tv[0]  = '{1'b1, 23'h7FFFFF, 23'h7FFFFF, 1'b1, 1'b1, 1'b1, 17'h1FFFE, 1'b0, 8'd0};
      tv[1]  = '{1'b0, 23'h0, 23'h0, 1'b0, 1'b0, 1'b1, 17'h0007F, 1'b1, 8'd1};
      tv[2]  = '{1'b0, 23'h0, 23'h0, 1'b0, 1'b1, 1'b0, 17'h0, 1'b0, 8'd0};
      // 0x10000+0x10000 -> limb 0 carry 1; 0+5+1 -> 6; flush 0
      tv[3]  = '{1'b1, 23'h10000, 23'h10000, 1'b0, 1'b1, 1'b1, 17'h00000, 1'b0, 8'd0};
      tv[4]  = '{1'b1, 23'h0, 23'h5, 1'b1, 1'b1, 1'b1, 17'h00006, 1'b0, 8'd1};
      tv[5]  = '{1'b0, 23'h0, 23'h0, 1'b0, 1'b0, 1'b1, 17'h00000, 1'b1, 8'd2};
      tv[6]  = '{1'b0, 23'h0, 23'h0, 1'b0, 1'b1, 1'b0, 17'h0, 1'b0, 8'd0};
      // back-to-back 3-column products of C=S=3FFFF: 1FFFE,1,2,flush 4; producer holds valid through flush
      tv[7]  = '{1'b1, 23'h3FFFF, 23'h3FFFF, 1'b0, 1'b1, 1'b1, 17'h1FFFE, 1'b0, 8'd0};
      tv[8]  = '{1'b1, 23'h3FFFF, 23'h3FFFF, 1'b0, 1'b1, 1'b1, 17'h00001, 1'b0, 8'd1};
      tv[9]  = '{1'b1, 23'h3FFFF, 23'h3FFFF, 1'b1, 1'b1, 1'b1, 17'h00002, 1'b0, 8'd2};
      tv[10] = '{1'b1, 23'h3FFFF, 23'h3FFFF, 1'b0, 1'b0, 1'b1, 17'h00004, 1'b1, 8'd3};
      tv[11] = '{1'b1, 23'h3FFFF, 23'h3FFFF, 1'b0, 1'b1, 1'b1, 17'h1FFFE, 1'b0, 8'd0};
      tv[12] = '{1'b1, 23'h3FFFF, 23'h3FFFF, 1'b0, 1'b1, 1'b1, 17'h00001, 1'b0, 8'd1};
      tv[13] = '{1'b1, 23'h3FFFF, 23'h3FFFF, 1'b1, 1'b1, 1'b1, 17'h00002, 1'b0, 8'd2};
      tv[14] = '{1'b0, 23'h0, 23'h0, 1'b0, 1'b0, 1'b1, 17'h00004, 1'b1, 8'd3};
      tv[15] = '{1'b0, 23'h0, 23'h0, 1'b0, 1'b1, 1'b0, 17'h0, 1'b0, 8'd0};

      reset_sq = 1'b1;
      bus.out_ready = 1'b1;
      drive(1'b0, 23'h0, 23'h0, 1'b0);
      repeat (2) @(posedge clk_sq);
      #1;
      chk("rst_valid", 0, 32'(bus.out_valid), 32'd0);
      chk("rst_limb", 0, 32'(bus.out_limb), 32'd0);
      chk("rst_last", 0, 32'(bus.out_last), 32'd0);
      chk("rst_ready", 0, 32'(bus.in_ready), 32'd1);
      @(negedge clk_sq);
      reset_sq = 1'b0;

      for (int i = 0; i < 16; i++) begin
         @(negedge clk_sq);
         drive(tv[i].v, tv[i].c, tv[i].s, tv[i].l);
         #1 chk("tbl_ready", i, 32'(bus.in_ready), 32'(tv[i].rdy));
         @(posedge clk_sq);
         #1 chk("tbl_valid", i, 32'(bus.out_valid), 32'(tv[i].ov));
         if (tv[i].ov) begin
            chk("tbl_limb", i, 32'(bus.out_limb), 32'(tv[i].limb));
            chk("tbl_last", i, 32'(bus.out_last), 32'(tv[i].lst));
`ifdef CS_LIMB_RESOLVER_IDX_EN
            chk("tbl_idx", i, 32'(bus.out_idx), 32'(tv[i].idx));
`endif
         end
      end

      // backpressure: 0x20000+5 -> limb 5 carry 1, then 0+0x10+1 -> 0x11, flush 0
      @(negedge clk_sq);
      drive(1'b1, 23'h20000, 23'h5, 1'b0);
      @(posedge clk_sq);
      #1 chk("bp_first", 0, {bus.out_valid, bus.out_limb}, {15'd0, 1'b1, 17'h5});
      @(negedge clk_sq);
      bus.out_ready = 1'b0;
      drive(1'b1, 23'h0, 23'h10, 1'b1);
      for (int k = 0; k < 5; k++) begin
         #1 chk("bp_ready", k, 32'(bus.in_ready), 32'd0);
         @(posedge clk_sq);
         #1 chk("bp_hold", k, {bus.out_valid, bus.out_limb}, {15'd0, 1'b1, 17'h5});
         @(negedge clk_sq);
      end
      bus.out_ready = 1'b1;
      #1 chk("bp_release_ready", 0, 32'(bus.in_ready), 32'd1);
      @(posedge clk_sq);
      #1 chk("bp_drain1", 0, {bus.out_valid, bus.out_last, bus.out_limb}, {14'd0, 2'b10, 17'h11});
      @(negedge clk_sq);
      drive(1'b0, 23'h0, 23'h0, 1'b0);
      @(posedge clk_sq);
      #1 chk("bp_drain2", 0, {bus.out_valid, bus.out_last, bus.out_limb}, {14'd0, 2'b11, 17'h0});
      @(posedge clk_sq);
      #1 chk("bp_empty", 0, 32'(bus.out_valid), 32'd0);

      // reset after the 2nd of 4 columns, then single column S=1 must see carry 0
      @(negedge clk_sq);
      drive(1'b1, 23'h3FFFF, 23'h3FFFF, 1'b0);
      @(posedge clk_sq);
      @(posedge clk_sq);
      @(negedge clk_sq);
      reset_sq = 1'b1;
      @(posedge clk_sq);
      #1 chk("mrst_valid", 0, 32'(bus.out_valid), 32'd0);
      chk("mrst_ready", 0, 32'(bus.in_ready), 32'd1);
      chk("mrst_limb", 0, 32'(bus.out_limb), 32'd0);
      @(negedge clk_sq);
      reset_sq = 1'b0;
      drive(1'b1, 23'h0, 23'h1, 1'b1);
      @(posedge clk_sq);
      #1 chk("mrst_col", 0, {bus.out_valid, bus.out_last, bus.out_limb}, {14'd0, 2'b10, 17'h1});
      @(negedge clk_sq);
      drive(1'b0, 23'h0, 23'h0, 1'b0);
      @(posedge clk_sq);
      #1 chk("mrst_flush", 0, {bus.out_valid, bus.out_last, bus.out_limb}, {14'd0, 2'b11, 17'h0});
      @(negedge clk_sq);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/cs_limb_resolver.md
# cs_limb_resolver

Carry-save resolver that sits downstream of the 66-input 23-bit column compressor tree in the squarer datapath. It accepts one column's redundant (C, S) pair per cycle, least-significant column first. It adds the pair to the running inter-column carry and emits a normalized LIMB_W-bit limb per column. After the last column it emits one final flush limb holding the residual carry, so a full carry-save product becomes a non-redundant limb stream.

## Interface
Parameters:
- IN_W, 23, width of each incoming C and S word
- LIMB_W, 17, width of each emitted limb
- CARRY_W, 8, inter-column carry width; must satisfy CARRY_W ≥ IN_W + 2 − LIMB_W

Ports:
- clk_sq  input  1  single clock; all state updates on posedge
- reset_sq  input  1  synchronous, active-high reset
- in_valid  input  1  column pair present
- in_ready  output  1  block accepts the column this cycle
- in_c  input  IN_W  carry word, already shifted/aligned by the producer
- in_s  input  IN_W  sum word
- in_last  input  1  marks the most-significant column of a product
- out_valid  output  1  limb present
- out_ready  input  1  consumer accepts the limb
- out_limb  output  LIMB_W  normalized limb
- out_last  output  1  marks the flush limb, which is the final limb of the product

## Operation
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Internal state: carry register (CARRY_W bits), one output register (out_limb/out_last/out_valid), FSM {ACCUM, FLUSH}.
- Output slot is free when !out_valid || out_ready.
- in_ready = (state==ACCUM) && slot free. It is combinational from state, out_valid and out_ready, and does not depend on in_valid.
- ACCUM, on input transfer:
  - sum = in_c + in_s + carry, computed at IN_W+2 bits with no truncation.
  - out_limb ← sum[LIMB_W-1:0]; out_last ← 0; out_valid ← 1.
  - carry ← sum[IN_W+1:LIMB_W], zero-extended to CARRY_W.
  - If in_last, go to FLUSH.
- FLUSH, when the slot is free:
  - out_limb ← carry zero-extended to LIMB_W; out_last ← 1; out_valid ← 1.
  - carry ← 0; go to ACCUM.
  - The flush limb is emitted even when carry is 0, so every product yields (columns + 1) limbs.
- Output transfer with no new load: out_valid ← 0. Simultaneous transfer and load: the new limb replaces the old one, with no bubble.
- Backpressure: out_valid and out_limb stay stable while out_valid && !out_ready.
- Single-column products (in_last on the first column) are legal.
- Reset values: out_valid=0, out_limb=0, out_last=0, carry=0, state=ACCUM. A reset mid-product discards all partial state and any pending limb. The next accepted column starts a new product with carry 0.

## Timing
- Latency: a column accepted in cycle n appears on out_limb at cycle n+1.
- Throughput: 1 column/cycle sustained when out_ready=1.
- Per-product overhead: one cycle with in_ready=0, while the flush limb is loaded.
- The flush limb appears one cycle after the last column's limb, provided out_ready was high.
- Critical path: one IN_W+2-bit three-operand add. No pipelining inside the add.

## Configuration
- CS_LIMB_RESOLVER_IDX_EN defined:
  - Adds output port out_idx (8 bits), the limb index within the current product.
  - out_idx is registered with out_limb. It is 0 for the first column and increments per loaded limb.
  - It resets to 0 after the flush limb and on reset_sq.
- Macro undefined: out_idx and its counter are absent. All other behaviour is identical.

## Test plan
- Single column, in_c=0x7FFFFF, in_s=0x7FFFFF, in_last=1, out_ready=1:
  - Limb 0x1FFFE (out_last=0) at cycle n+1.
  - Limb 0x0007F (out_last=1) at cycle n+2.
- Two columns, {C=0x10000, S=0x10000}, then {C=0, S=5, last}:
  - Limbs 0x00000, 0x00006, then flush 0x00000 with out_last=1.
- Backpressure: hold out_ready=0 for 5 cycles after the first limb.
  - out_limb stays stable, in_ready=0, no column is lost.
  - On release, the limbs drain in order.
- Back-to-back products, each 3 columns of C=S=0x3FFFF:
  - 8 limbs total, with out_last on limbs 4 and 8.
  - Carry of the first product does not leak into the second.
  - Exactly one in_ready=0 cycle per flush.
- Reset asserted in the cycle after the 2nd of 4 columns:
  - Next cycle: out_valid=0, state ACCUM.
  - A following single column C=0, S=1 (last) yields limbs 0x00001 and 0x00000, i.e. carry was cleared.
- With CS_LIMB_RESOLVER_IDX_EN: a 3-column product gives out_idx 0,1,2,3, then 0 on the next product.
